// File: rtl/mult_share_arb.sv
`default_nettype none
// ============================================================================
// Module   : mult_share_arb
// Brief    : Shares one Q1.15 x B_DATA_W multiplier among NUM_CH requesters
//            with channel-tagged results and per-channel result registers.
//            Define MULT_ARB_FIXED_PRIO_EN for lowest-index-first priority.
// Revision : 1.0 - initial release
// ============================================================================
module mult_share_arb #(
  parameter int NUM_CH   = 4,
  parameter int A_DATA_W = 16,
  parameter int B_DATA_W = 24,
  parameter int MULT_LAT = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_CH-1:0]            i_req_valid,
  input  logic [NUM_CH*A_DATA_W-1:0]   i_req_a,
  input  logic [NUM_CH*B_DATA_W-1:0]   i_req_b,
  output logic [NUM_CH-1:0]            o_req_ready,
  output logic [NUM_CH-1:0]            o_res_valid,
  output logic [NUM_CH*B_DATA_W-1:0]   o_res_c,
  input  logic [NUM_CH-1:0]            i_res_ready,
  output logic                         o_m_valid,
  output logic                         o_m_ready,
  output logic [A_DATA_W-1:0]          o_m_a,
  output logic [B_DATA_W-1:0]          o_m_b,
  input  logic                         i_m_valid,
  input  logic [B_DATA_W-1:0]          i_m_c
);

  localparam int c_ch_w = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]   busy_q, busy_d;
  logic [NUM_CH-1:0]   res_vld_q, res_vld_d;
  logic [B_DATA_W-1:0] res_q [NUM_CH];
  logic [B_DATA_W-1:0] res_d [NUM_CH];
  logic [MULT_LAT-1:0] tag_vld_q, tag_vld_d;
  logic [c_ch_w-1:0]   tag_ch_q [MULT_LAT];
  logic [c_ch_w-1:0]   tag_ch_d [MULT_LAT];
  logic                err_q, err_d;
`ifndef MULT_ARB_FIXED_PRIO_EN
  localparam logic [c_ch_w:0] c_num_ch = (c_ch_w+1)'(NUM_CH);
  logic [c_ch_w-1:0]   rr_ptr_q, rr_ptr_d;
  logic [c_ch_w:0]     w_idx;
`endif

  logic [NUM_CH-1:0]   w_eligible;
  logic [NUM_CH-1:0]   w_drain;
  logic                w_grant_vld;
  logic [c_ch_w-1:0]   w_grant_ch;
  logic                w_head_vld;
  logic [c_ch_w-1:0]   w_head_ch;

  // A channel stays busy until its result is consumed, so a returning
  // product always finds its result register empty.
  assign w_drain    = res_vld_q & i_res_ready;
  assign w_eligible = i_req_valid & ~busy_q;
  assign w_head_vld = tag_vld_q[MULT_LAT-1];
  assign w_head_ch  = tag_ch_q[MULT_LAT-1];

  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_ch  = '0;
`ifdef MULT_ARB_FIXED_PRIO_EN
    for (int i = 0; i < NUM_CH; i++) begin
      if (!w_grant_vld && w_eligible[i]) begin
        w_grant_vld = 1'b1;
        w_grant_ch  = c_ch_w'(i);
      end
    end
`else
    w_idx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_idx = {1'b0, rr_ptr_q} + (c_ch_w+1)'(i);
      if (w_idx >= c_num_ch) begin
        w_idx = w_idx - c_num_ch;
      end
      if (!w_grant_vld && w_eligible[w_idx[c_ch_w-1:0]]) begin
        w_grant_vld = 1'b1;
        w_grant_ch  = w_idx[c_ch_w-1:0];
      end
    end
`endif
    if (reset) begin
      w_grant_vld = 1'b0;
      w_grant_ch  = '0;
    end
  end

  always_comb begin
    o_req_ready = '0;
    o_m_valid   = w_grant_vld;
    o_m_ready   = ~reset;
    o_m_a       = '0;
    o_m_b       = '0;
    if (w_grant_vld) begin
      o_req_ready[w_grant_ch] = 1'b1;
      o_m_a = i_req_a[int'(w_grant_ch)*A_DATA_W +: A_DATA_W];
      o_m_b = i_req_b[int'(w_grant_ch)*B_DATA_W +: B_DATA_W];
    end
  end

  always_comb begin
    tag_vld_d    = '0;
    tag_vld_d[0] = w_grant_vld;
    tag_ch_d[0]  = w_grant_ch;
    for (int i = 1; i < MULT_LAT; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_ch_d[i]  = tag_ch_q[i-1];
    end
  end

  // A result with no matching tag is dropped; a tag with no result is flagged.
  always_comb begin
    busy_d    = busy_q & ~w_drain;
    res_vld_d = res_vld_q & ~w_drain;
    res_d     = res_q;
    err_d     = err_q | (w_head_vld & ~i_m_valid);
    if (w_grant_vld) begin
      busy_d[w_grant_ch] = 1'b1;
    end
    if (i_m_valid && w_head_vld) begin
      res_vld_d[w_head_ch] = 1'b1;
      res_d[w_head_ch]     = i_m_c;
    end
  end

`ifndef MULT_ARB_FIXED_PRIO_EN
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (w_grant_vld) begin
      rr_ptr_d = (w_grant_ch == c_ch_w'(NUM_CH-1)) ? '0 : w_grant_ch + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q    <= '0;
      res_vld_q <= '0;
      tag_vld_q <= '0;
      err_q     <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        res_q[k] <= '0;
      end
      for (int i = 0; i < MULT_LAT; i++) begin
        tag_ch_q[i] <= '0;
      end
`ifndef MULT_ARB_FIXED_PRIO_EN
      rr_ptr_q  <= '0;
`endif
    end else begin
      busy_q    <= busy_d;
      res_vld_q <= res_vld_d;
      tag_vld_q <= tag_vld_d;
      err_q     <= err_d;
      for (int k = 0; k < NUM_CH; k++) begin
        res_q[k] <= res_d[k];
      end
      for (int i = 0; i < MULT_LAT; i++) begin
        tag_ch_q[i] <= tag_ch_d[i];
      end
`ifndef MULT_ARB_FIXED_PRIO_EN
      rr_ptr_q  <= rr_ptr_d;
`endif
    end
  end

  assign o_res_valid = res_vld_q;

  generate
    for (genvar k = 0; k < NUM_CH; k++) begin : g_res_out
      assign o_res_c[k*B_DATA_W +: B_DATA_W] = res_q[k];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_mult_share_arb.sv
`default_nettype none
// Bench for mult_share_arb: two instances (MULT_LAT 1 and 3) share one stimulus;
// a per-channel pending-result model predicts every output each cycle.
module tb_mult_share_arb;

  localparam int NCH = 4;
  localparam int AW  = 16;
  localparam int BW  = 24;
  localparam int CW  = NCH * BW;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [NCH-1:0]  req_valid = '0;
  logic [NCH-1:0]  res_ready = '0;
  logic [NCH*AW-1:0] req_a = '0;
  logic [NCH*BW-1:0] req_b = '0;

  logic [NCH-1:0]  req_ready [2];
  logic [NCH-1:0]  res_valid [2];
  logic [CW-1:0]   res_c     [2];
  logic            m_valid   [2];
  logic            m_ready   [2];
  logic [AW-1:0]   m_a       [2];
  logic [BW-1:0]   m_b       [2];

  always #5 clk = ~clk;

  function automatic logic [BW-1:0] qmul(input logic [AW-1:0] a, input logic [BW-1:0] b);
    logic signed [AW+BW-1:0] p;
    p = $signed(a) * $signed(b);
    return p[BW+14:15];
  endfunction

  // Behavioural multipliers: latency 1 and latency 3, not reset.
  logic          p1_v = 1'b0;
  logic [BW-1:0] p1_c = '0;
  logic [2:0]    p3_v = '0;
  logic [BW-1:0] p3_c [3];

  always @(posedge clk) begin
    p1_v    <= m_valid[0] & m_ready[0];
    p1_c    <= qmul(m_a[0], m_b[0]);
    p3_v    <= {p3_v[1:0], m_valid[1] & m_ready[1]};
    p3_c[0] <= qmul(m_a[1], m_b[1]);
    p3_c[1] <= p3_c[0];
    p3_c[2] <= p3_c[1];
  end

  mult_share_arb #(.NUM_CH(NCH), .A_DATA_W(AW), .B_DATA_W(BW), .MULT_LAT(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .i_req_valid(req_valid), .i_req_a(req_a), .i_req_b(req_b),
    .o_req_ready(req_ready[0]), .o_res_valid(res_valid[0]), .o_res_c(res_c[0]),
    .i_res_ready(res_ready),
    .o_m_valid(m_valid[0]), .o_m_ready(m_ready[0]), .o_m_a(m_a[0]), .o_m_b(m_b[0]),
    .i_m_valid(p1_v), .i_m_c(p1_c)
  );

  mult_share_arb #(.NUM_CH(NCH), .A_DATA_W(AW), .B_DATA_W(BW), .MULT_LAT(3)) u_dut3 (
    .clk(clk), .reset(reset),
    .i_req_valid(req_valid), .i_req_a(req_a), .i_req_b(req_b),
    .o_req_ready(req_ready[1]), .o_res_valid(res_valid[1]), .o_res_c(res_c[1]),
    .i_res_ready(res_ready),
    .o_m_valid(m_valid[1]), .o_m_ready(m_ready[1]), .o_m_a(m_a[1]), .o_m_b(m_b[1]),
    .i_m_valid(p3_v[2]), .i_m_c(p3_c[2])
  );

  // Model: per channel, a busy flag and at most one pending result with its due cycle.
  int            lat [2] = '{1, 3};
  logic [NCH-1:0] m_busy [2];
  logic [NCH-1:0] m_rv   [2];
  logic [BW-1:0]  m_res  [2][NCH];
  logic [BW-1:0]  m_val  [2][NCH];
  int             m_due  [2][NCH];
  int             m_ptr  [2];
  int             cyc = 0;

  logic [NCH-1:0] s_rr [2];
  logic [NCH-1:0] s_rv [2];
  logic [CW-1:0]  s_rc [2];
  logic [CW-1:0]  s_mb [2];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d: got %h want %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_cycle();
    for (int d = 0; d < 2; d++) begin
      logic [NCH-1:0] e_rr;
      logic [CW-1:0]  e_rc;
      logic [AW-1:0]  e_ma;
      logic [BW-1:0]  e_mb;
      logic           e_mv;
      int             g;
      g    = -1;
      e_rr = '0;
      e_mv = 1'b0;
      e_ma = '0;
      e_mb = '0;
      if (reset) begin
        m_busy[d] = '0;
        m_rv[d]   = '0;
        m_ptr[d]  = 0;
        for (int k = 0; k < NCH; k++) begin
          m_res[d][k] = '0;
          m_val[d][k] = '0;
          m_due[d][k] = -1;
        end
      end else begin
        for (int k = 0; k < NCH; k++) begin
          if (m_due[d][k] == cyc) begin
            m_rv[d][k]  = 1'b1;
            m_res[d][k] = m_val[d][k];
            m_due[d][k] = -1;
          end
        end
        for (int i = 0; i < NCH; i++) begin
          int k;
`ifdef MULT_ARB_FIXED_PRIO_EN
          k = i;
`else
          k = (m_ptr[d] + i) % NCH;
`endif
          if (g < 0 && req_valid[k] && !m_busy[d][k]) g = k;
        end
        if (g >= 0) begin
          e_rr[g] = 1'b1;
          e_mv    = 1'b1;
          e_ma    = req_a[g*AW +: AW];
          e_mb    = req_b[g*BW +: BW];
        end
      end
      for (int k = 0; k < NCH; k++) e_rc[k*BW +: BW] = m_res[d][k];

      s_rr[d] = req_ready[d];
      s_rv[d] = res_valid[d];
      s_rc[d] = res_c[d];
      s_mb[d] = CW'({m_valid[d], m_ready[d], m_a[d], m_b[d]});
      check($sformatf("lat%0d req_ready", lat[d]), CW'(req_ready[d]), CW'(e_rr));
      check($sformatf("lat%0d res_valid", lat[d]), CW'(res_valid[d]), CW'(m_rv[d]));
      check($sformatf("lat%0d res_c", lat[d]), res_c[d], e_rc);
      check($sformatf("lat%0d mult_bus", lat[d]), s_mb[d], CW'({e_mv, ~reset, e_ma, e_mb}));

      if (!reset) begin
        for (int k = 0; k < NCH; k++) begin
          if (m_rv[d][k] && res_ready[k]) begin
            m_rv[d][k]   = 1'b0;
            m_busy[d][k] = 1'b0;
          end
        end
        if (g >= 0) begin
          m_busy[d][g] = 1'b1;
          m_due[d][g]  = cyc + lat[d] + 1;
          m_val[d][g]  = qmul(req_a[g*AW +: AW], req_b[g*BW +: BW]);
          m_ptr[d]     = (g + 1) % NCH;
        end
      end
    end
    cyc++;
  endtask

  task automatic step();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ab(input int k, input logic [AW-1:0] a, input logic [BW-1:0] b);
    req_a[k*AW +: AW] = a;
    req_b[k*BW +: BW] = b;
  endtask

`ifdef MULT_ARB_FIXED_PRIO_EN
  logic [NCH-1:0] exp_b [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b0001};
`else
  logic [NCH-1:0] exp_b [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif

  initial begin
    int cnt [2];

    // Reset state
    step();
    check("reset res_valid", CW'(s_rv[0]), '0);
    check("reset res_c", s_rc[1], '0);
    check("reset mult_bus", s_mb[0], '0);
    step();

    // Single request on ch0: 0.5 * 0x100000
    reset     = 1'b0;
    req_valid = 4'b0001;
    set_ab(0, 16'h4000, 24'h100000);
    step();
    check("ch0 grant", CW'(s_rr[0]), CW'(4'b0001));
    req_valid = '0;
    step();
    step();
    check("ch0 lat1 valid", CW'(s_rv[0]), CW'(4'b0001));
    check("ch0 lat1 data", CW'(s_rc[0][23:0]), CW'(24'h080000));
    step();
    step();
    check("ch0 lat1 held", CW'(s_rv[0]), CW'(4'b0001));
    check("ch0 lat3 valid", CW'(s_rv[1]), CW'(4'b0001));
    check("ch0 lat3 data", CW'(s_rc[1][23:0]), CW'(24'h080000));
    res_ready = 4'b0001;
    step();
    res_ready = '0;
    step();
    check("ch0 lat1 drained", CW'(s_rv[0]), '0);
    check("ch0 lat3 drained", CW'(s_rv[1]), '0);

    // All channels requesting, all consumers ready
    req_valid = 4'b1111;
    res_ready = 4'b1111;
    for (int i = 0; i < 20; i++) begin
      for (int k = 0; k < NCH; k++) begin
        set_ab(k, AW'(32'h0800 + k*32'h1357 + i*32'h0421),
                  BW'(32'h012345 * (k+1) + i*32'h0F0F0F));
      end
      step();
      if (i < 4) check($sformatf("rr order %0d", i), CW'(s_rr[0]), CW'(exp_b[i]));
    end

    // ch2 consumer stalls for 10 cycles
    res_ready = 4'b1011;
    cnt = '{0, 0};
    for (int i = 0; i < 10; i++) begin
      step();
      if (i >= 5) begin
        if (s_rr[0][2]) cnt[0]++;
        if (s_rr[1][2]) cnt[1]++;
      end
    end
    check("ch2 stall no grant lat1", CW'(cnt[0]), '0);
    check("ch2 stall no grant lat3", CW'(cnt[1]), '0);
    check("ch2 stall held lat3", CW'(s_rv[1][2]), CW'(1'b1));
    res_ready = 4'b1111;
    step();
    check("ch2 release no same-cycle grant", CW'({s_rr[0][2], s_rr[1][2]}), '0);
    step();
    step();

    // Reset with products in flight
    reset     = 1'b1;
    req_valid = '0;
    step();
    check("mid reset res_valid", CW'({s_rv[0], s_rv[1]}), '0);
    check("mid reset mult_bus", s_mb[1], '0);
    reset = 1'b0;
    cnt = '{0, 0};
    for (int i = 0; i < 6; i++) begin
      step();
      if (s_rv[0] != '0) cnt[0]++;
      if (s_rv[1] != '0) cnt[1]++;
    end
    check("stray results ignored lat1", CW'(cnt[0]), '0);
    check("stray results ignored lat3", CW'(cnt[1]), '0);

    // ch1 and ch3 interleaved
    req_valid = 4'b1010;
    set_ab(0, '0, '0);
    set_ab(2, '0, '0);
    set_ab(1, 16'h2000, 24'h040000);
    set_ab(3, 16'hC000, 24'h200000);
    step();
    check("ilv first grant", CW'(s_rr[1]), CW'(4'b0010));
    step();
    step();
    check("ilv lat1 ch1 data", CW'(s_rc[0][47:24]), CW'(24'h010000));
    step();
    check("ilv lat1 ch3 data", CW'(s_rc[0][95:72]), CW'(24'hF00000));
    step();
    check("ilv lat3 ch1 valid", CW'(s_rv[1][1]), CW'(1'b1));
    check("ilv lat3 ch1 data", CW'(s_rc[1][47:24]), CW'(24'h010000));
    step();
    check("ilv lat3 ch3 valid", CW'(s_rv[1][3]), CW'(1'b1));
    check("ilv lat3 ch3 data", CW'(s_rc[1][95:72]), CW'(24'hF00000));
    for (int i = 0; i < 8; i++) step();

    check("error flag lat1", CW'(u_dut1.err_q), '0);
    check("error flag lat3", CW'(u_dut3.err_q), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
